// File: rtl/mote_cmd_encoder_if.sv
// Host-side command/status bundle for the mote command encoder.
// The line output rides along so the driver side sees one bundle.
interface mote_cmd_encoder_if;
    logic       start;
    logic [3:0] amplitude_in;
    logic [7:0] n_scan;
    logic       abort;
    logic       DATA_OUT;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output amplitude_in,
        output n_scan,
        output abort,
        input  DATA_OUT,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  amplitude_in,
        input  n_scan,
        input  abort,
        output DATA_OUT,
        output busy,
        output done
    );
endinterface

// File: rtl/mote_cmd_encoder.sv
// Toggle-coded DATA_OUT sequencer: preamble, start edge, 4-bit amplitude word,
// scan-arm edge and 2*n_scan scan edges, driven by a single 16-bit interval counter.
module mote_cmd_encoder #(
    parameter int unsigned PRE_GAP     = 100,
    parameter int unsigned SYM_SHORT   = 4,
    parameter int unsigned SYM_LONG    = 12,
    parameter int unsigned BIT_GAP     = 8,
    parameter int unsigned HALF_PERIOD = 50
) (
    input logic              CLK_IN,
    input logic              rst_n,
    mote_cmd_encoder_if.slave bus
);

    localparam logic [15:0] PreGap   = 16'(PRE_GAP);
    localparam logic [15:0] SymShort = 16'(SYM_SHORT);
    localparam logic [15:0] SymLong  = 16'(SYM_LONG);
    localparam logic [15:0] BitGap   = 16'(BIT_GAP);
    localparam logic [15:0] HalfPer  = 16'(HALF_PERIOD);

    typedef enum logic [3:0] {
        StIdle,
        StPre,
        StStart,
        StBitA,
        StBitB,
        StBitEnd,
        StArm,
        StScan,
        StFin
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic [1:0]  idx_q;
    logic [8:0]  scan_q;
    logic [3:0]  amp_q;
    logic [7:0]  nscan_q;
    logic        data_q;
    logic        busy_q;
    logic        done_q;

    logic        fire;
    logic [1:0]  idx_dec;

    // Bit 1 is long-then-short, bit 0 short-then-long.
    function automatic logic [15:0] phase_a(input logic b);
        return b ? SymLong : SymShort;
    endfunction

    function automatic logic [15:0] phase_b(input logic b);
        return b ? SymShort : SymLong;
    endfunction

    assign fire    = (cnt_q == 16'd1);
    assign idx_dec = idx_q - 2'd1;

    always_ff @(posedge CLK_IN or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            scan_q  <= '0;
            amp_q   <= '0;
            nscan_q <= '0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q != StIdle && bus.abort) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (cnt_q != 16'd0) begin
                cnt_q <= cnt_q - 16'd1;
            end
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        amp_q   <= bus.amplitude_in;
                        nscan_q <= bus.n_scan;
                        data_q  <= ~data_q;
                        busy_q  <= 1'b1;
                        cnt_q   <= PreGap;
                        idx_q   <= 2'd0;
                        state_q <= StPre;
                    end
                end
                StPre: begin
                    if (fire) begin
                        data_q <= ~data_q;
                        cnt_q  <= PreGap;
                        if (idx_q == 2'd1) begin
                            state_q <= StStart;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end
                StStart: begin
                    if (fire) begin
                        data_q  <= ~data_q;
                        idx_q   <= 2'd3;
                        cnt_q   <= phase_a(amp_q[3]);
                        state_q <= StBitA;
                    end
                end
                StBitA: begin
                    if (fire) begin
                        data_q  <= ~data_q;
                        cnt_q   <= phase_b(amp_q[idx_q]);
                        state_q <= StBitB;
                    end
                end
                StBitB: begin
                    if (fire) begin
                        data_q  <= ~data_q;
                        cnt_q   <= BitGap;
                        state_q <= StBitEnd;
                    end
                end
                StBitEnd: begin
                    if (fire) begin
                        data_q <= ~data_q;
                        if (idx_q == 2'd0) begin
                            cnt_q   <= PreGap;
                            state_q <= StArm;
                        end else begin
                            idx_q   <= idx_dec;
                            cnt_q   <= phase_a(amp_q[idx_dec]);
                            state_q <= StBitA;
                        end
                    end
                end
                StArm: begin
                    if (fire) begin
                        data_q <= ~data_q;
                        if (nscan_q == 8'd0) begin
                            cnt_q   <= '0;
                            state_q <= StFin;
                        end else begin
                            scan_q  <= {nscan_q, 1'b0};
                            cnt_q   <= HalfPer;
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    if (fire) begin
                        data_q <= ~data_q;
                        scan_q <= scan_q - 9'd1;
                        if (scan_q == 9'd1) begin
                            cnt_q   <= '0;
                            state_q <= StFin;
                        end else begin
                            cnt_q <= HalfPer;
                        end
                    end
                end
                StFin: begin
                    // First FIN cycle is the last edge cycle; the pulse lands one cycle later.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DATA_OUT = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_mote_cmd_encoder.sv
// Scoreboard bench: expected edge/done cycles and busy windows come from a
// timeline model of the transaction; a monitor checks the DUT every cycle.
module tb_mote_cmd_encoder;

    localparam int Pre = 100;
    localparam int Ss  = 4;
    localparam int Sl  = 12;
    localparam int Gap = 8;
    localparam int Hp  = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;

    int   eq[$];
    int   dq[$];
    int   bw_start = 1;
    int   bw_end   = 0;

    mote_cmd_encoder_if bus_if ();

    mote_cmd_encoder #(
        .PRE_GAP    (Pre),
        .SYM_SHORT  (Ss),
        .SYM_LONG   (Sl),
        .BIT_GAP    (Gap),
        .HALF_PERIOD(Hp)
    ) dut (
        .CLK_IN(clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Timeline of one transaction straight from the edge-interval rules.
    function automatic void model(input int t0, input logic [3:0] a, input int n);
        int t;
        t = t0 + 1;
        eq.push_back(t);
        for (int i = 0; i < 3; i++) begin
            t += Pre;
            eq.push_back(t);
        end
        for (int k = 3; k >= 0; k--) begin
            t += a[k] ? Sl : Ss;
            eq.push_back(t);
            t += a[k] ? Ss : Sl;
            eq.push_back(t);
            t += Gap;
            eq.push_back(t);
        end
        t += Pre;
        eq.push_back(t);
        for (int i = 0; i < 2 * n; i++) begin
            t += Hp;
            eq.push_back(t);
        end
        bw_start = t0 + 1;
        bw_end   = t;
        dq.push_back(t + 1);
    endfunction

    function automatic void purge(input int ta);
        while (eq.size() != 0 && eq[$] > ta) void'(eq.pop_back());
        dq.delete();
        bw_end = ta;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        logic prev;
        logic exp_e;
        logic exp_d;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                exp_e = (eq.size() != 0 && eq[0] == cyc);
                if (exp_e) void'(eq.pop_front());
                check("edge", 32'(bus_if.DATA_OUT != prev), 32'(exp_e));
                prev = bus_if.DATA_OUT;
                exp_d = (dq.size() != 0 && dq[0] == cyc);
                if (exp_d) void'(dq.pop_front());
                check("done", 32'(bus_if.done), 32'(exp_d));
                check("busy", 32'(bus_if.busy), 32'(cyc >= bw_start && cyc <= bw_end));
            end
        end
    end

    // Call at a falling edge with the DUT idle.
    task automatic launch(input logic [3:0] a, input logic [7:0] n, output int t0);
        bus_if.start        = 1'b1;
        bus_if.amplitude_in = a;
        bus_if.n_scan       = n;
        t0 = cyc;
        model(t0, a, int'(n));
        @(negedge clk);
        bus_if.start        = 1'b0;
        bus_if.amplitude_in = 4'($urandom);
        bus_if.n_scan       = 8'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc < bw_end + 3) @(negedge clk);
    endtask

    task automatic do_abort();
        bus_if.abort = 1'b1;
        purge(cyc);
        @(negedge clk);
        bus_if.abort = 1'b0;
    endtask

    initial begin
        int t0;
        int off;
        logic [3:0] a;
        logic [7:0] n;
        bus_if.start        = 1'b0;
        bus_if.abort        = 1'b0;
        bus_if.amplitude_in = 4'd0;
        bus_if.n_scan       = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_data", 32'(bus_if.DATA_OUT), 0);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_done", 32'(bus_if.done), 0);
        repeat (4) @(negedge clk);

        // Default run with a stray start mid-transaction.
        launch(4'b1010, 8'd2, t0);
        while (cyc < t0 + 50) @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.amplitude_in = 4'h5;
        bus_if.n_scan = 8'd9;
        @(negedge clk);
        bus_if.start = 1'b0;
        wait_idle();

        // start together with abort in IDLE must do nothing.
        bus_if.start = 1'b1;
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        repeat (20) @(negedge clk);

        launch(4'b0000, 8'd0, t0);
        wait_idle();
        launch(4'b1111, 8'd3, t0);
        wait_idle();

        // Abort mid bit 3, then a fresh start.
        launch(4'b1010, 8'd2, t0);
        while (cyc < t0 + 320) @(negedge clk);
        do_abort();
        while (cyc < t0 + 400) @(negedge clk);
        launch(4'b1010, 8'd2, t0);
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom);
            n = 8'($urandom_range(0, 4));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            launch(a, n, t0);
            if ($urandom_range(0, 2) == 0) begin
                off = $urandom_range(1, bw_end - t0);
                while (cyc < t0 + off) @(negedge clk);
                do_abort();
                repeat (3) @(negedge clk);
            end else begin
                wait_idle();
            end
        end

        // Asynchronous reset between clock edges mid-transaction.
        launch(4'b1010, 8'd2, t0);
        while (cyc < t0 + 250) @(negedge clk);
        #3;
        rst_n = 1'b0;
        eq.delete();
        dq.delete();
        bw_start = 1;
        bw_end   = 0;
        #1;
        check("arst_data", 32'(bus_if.DATA_OUT), 0);
        check("arst_busy", 32'(bus_if.busy), 0);
        check("arst_done", 32'(bus_if.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        launch(4'b0110, 8'd1, t0);
        wait_idle();

        check("edges_left", 32'(eq.size()), 0);
        check("dones_left", 32'(dq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mote_cmd_encoder.md
Name: mote_cmd_encoder

Overview:
- Base-station-side sequencer that generates the toggle-coded DATA_OUT stream consumed by the dust-mote receiver FSM.
- Sequence per transaction: 3-edge preamble, start edge, 4-bit amplitude word (MSB first, add/subtract duration coding), scan-arm edge, then 2*n_scan scan edges driving the mote between positive and negative current.
- Sits between the host command interface and the line driver.
- Is the sole owner of mote configuration and scan timing.

Parameters:
- PRE_GAP, 100: cycles between preamble edges, before the start edge, and before the scan-arm edge. Must satisfy 1 ≤ PRE_GAP ≤ receiver TIMEOUT (1000).
- SYM_SHORT, 4: short phase length in cycles. Must be ≥ 1.
- SYM_LONG, 12: long phase length in cycles. Must satisfy SYM_SHORT < SYM_LONG ≤ SYM_SHORT+15, so the receiver's 5-bit accumulator does not wrap.
- BIT_GAP, 8: cycles from a bit's end edge to the next bit's start edge. Must be ≥ 1.
- HALF_PERIOD, 50: cycles between scan edges. Must be ≥ 1.
- All gap parameters must be ≤ 65535. The internal interval counter is 16 bits.

Ports:
- CLK_IN  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- amplitude_in  in  4  amplitude word; latched when start is accepted.
- n_scan  in  8  number of scan periods (edge pairs); latched when start is accepted.
- abort  in  1  terminates the transaction; has priority over start.
- DATA_OUT  out  1  toggle-coded line to the mote; every level change is one edge.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at normal completion.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; DATA_OUT=0, busy=0, done=0.
  - Latched registers and counters cleared.
  - Reset mid-transaction aborts immediately, with no done pulse.
- Edges: an edge is the inversion of DATA_OUT on a clock edge. DATA_OUT otherwise holds its level and is never returned to 0 between transactions.
- States: IDLE, PRE, START, BIT_A, BIT_B, BIT_END, ARM, SCAN, FIN.
- Timing, with t0 = the cycle where start=1 is sampled in IDLE and abort=0:
  - PRE: edge 1 at t0+1; edges 2 and 3 at +PRE_GAP each.
  - START: start edge at +PRE_GAP after edge 3.
  - Per bit, k = 3..0:
    - BIT_A ends with an edge after A cycles.
    - BIT_B ends with an edge after B cycles.
    - BIT_END ends with an edge after BIT_GAP cycles.
    - Bit=1 gives A=SYM_LONG, B=SYM_SHORT. Bit=0 gives A=SYM_SHORT, B=SYM_LONG.
    - Bit k-1's A interval starts at bit k's BIT_END edge.
  - ARM: edge at +PRE_GAP after bit 0's BIT_END edge.
  - SCAN: 2*n_scan edges, each HALF_PERIOD after the previous one.
  - n_scan=0 skips SCAN.
  - FIN: the cycle after the last edge, done=1 and busy=0. Next cycle returns to IDLE.
- Edge count per transaction: 17 + 2*n_scan.
- Interval counter:
  - Loads the interval length at each edge (and at t0 for PRE).
  - Decrements each cycle; the edge fires when it reaches 1.
  - Wrap-around is impossible by the parameter constraints.
- busy: 1 from t0+1 through the last edge cycle.
- start while not IDLE: ignored. amplitude_in and n_scan changes after acceptance have no effect.
- abort=1 in any non-IDLE state:
  - Next state IDLE; DATA_OUT holds its current level.
  - busy=0 next cycle; no done pulse.
- start and abort both high in IDLE: start ignored.
- done never coincides with an edge.

Test Plan:
- Defaults, amplitude_in=4'b1010, n_scan=2, start at cycle 0 -> edges at cycles 1,101,201,301, 313,317,325, 329,341,349, 361,365,373, 377,389,397, 497, 547,597,647,697. done=1 at 698 only; busy=1 over 1..697.
- amplitude_in=4'b0000, n_scan=0 -> 17 edges. Each bit has A=4, B=12. Arm edge at cycle 1+300+3*(24)+... (check against spec formula). done the cycle after the arm edge. Loopback into the receiver FSM yields amplitude=0.
- amplitude_in=4'b1111, n_scan=3 looped into the receiver FSM -> receiver reaches WaitScan then SendPos, amplitude=4'hF. 23 total edges. GLED5 toggles 6 times after SendPos entry.
- abort asserted at cycle 320 (mid bit 3, default run) -> busy=0 from 321, no further edges, DATA_OUT frozen, no done. A new start at 400 begins a fresh preamble at 401.
- start pulsed at cycle 50 during a busy transaction, and start+abort together in IDLE -> both ignored; edge timing of the running transaction is unchanged.
- rst_n driven low at cycle 250 asynchronously (between clock edges) -> DATA_OUT, busy, done = 0 immediately. After release, no edges until a new start.
